// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, control opcodes, sink error
// codes and default widths used by the traffic generator/sink pair.
package noc_pkg;

  // Default widths of the destination field and per-packet length counter.
  localparam int NOC_DEST_W = 14;
  localparam int NOC_LEN_W  = 10;

  // Flit framing bits; the VC field starts at VC_LSB and the destination
  // field follows immediately above the VC field.
  localparam int HEAD_BIT = 0;
  localparam int TAIL_BIT = 1;
  localparam int VC_LSB   = 2;

  // Position of the expected packet total inside the control data word.
  localparam int TOTAL_LSB = 22;
  localparam int TOTAL_W   = 10;

  // Control opcodes shared with the generator; the sink only reacts to Init.
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_FILL    = 3'd1,
    OP_DEQUEUE = 3'd2,
    OP_INIT    = 3'd5
  } op_e;

  // First-error code reported by the sink.
  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_HEAD_IN_PKT = 2'd1,
    ERR_ORPHAN_BODY = 2'd2,
    ERR_BAD_DEST    = 2'd3
  } err_code_e;

  // Per-VC reassembly state.
  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_BODY = 1'b1
  } vc_state_e;

  // Destination field offset for a given VC index width.
  function automatic int dst_lsb(input int vc_w);
    return VC_LSB + vc_w;
  endfunction

endpackage

// File: rtl/traffic_sink_vc_tracker.sv
// Per-VC packet reassembly: tracks head/tail framing for one VC, counts the
// packet length and flags framing violations for the flits steered to it.
module traffic_sink_vc_tracker
  import noc_pkg::*;
#(
  parameter int LEN_W = NOC_LEN_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,              // Init: abandon any packet in progress
  input  logic flit_en,          // an accepted flit belongs to this VC
  input  logic head,
  input  logic tail,
  output logic pkt_done,         // a packet completes with this flit
  output logic err_head_in_pkt,  // head arrived while a packet was open
  output logic err_orphan,       // body/tail arrived with no open packet
  output logic idle              // VC is idle once this cycle's flit is applied
);

  vc_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;

  // State and length registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    if (rst) begin
      state_q <= VC_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // Next-state, length and event decode for the flit presented this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d         = state_q;
    len_d           = len_q;
    pkt_done        = 1'b0;
    err_head_in_pkt = 1'b0;
    err_orphan      = 1'b0;

    if (clr) begin
      state_d = VC_IDLE;
      len_d   = '0;
    end else if (flit_en) begin
      unique case (state_q)
        VC_IDLE: begin
          if (head && tail) begin
            pkt_done = 1'b1;
          end else if (head) begin
            state_d = VC_BODY;
            len_d   = LEN_W'(1);
          end else begin
            err_orphan = 1'b1;
          end
        end
        VC_BODY: begin
          if (head) begin
            // Abandon the open packet and restart from this head.
            err_head_in_pkt = 1'b1;
            if (tail) begin
              pkt_done = 1'b1;
              state_d  = VC_IDLE;
              len_d    = '0;
            end else begin
              len_d = LEN_W'(1);
            end
          end else if (tail) begin
            pkt_done = 1'b1;
            state_d  = VC_IDLE;
            len_d    = '0;
          end else if (len_q != '1) begin
            len_d = len_q + 1'b1;
          end
        end
        default: state_d = VC_IDLE;
      endcase
    end
  end

  assign idle = (state_d == VC_IDLE);

endmodule

// File: rtl/traffic_sink.sv
// NoC ejection sink: consumes one flit per cycle, returns a credit one cycle
// later, reassembles packets per VC, counts packets/flits and flags errors.
module traffic_sink
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int VC_NUM = 4,
  parameter int VC_W   = 2,
  parameter int DEST_W = NOC_DEST_W,
  parameter int FLIT_W = 32,
  parameter int LEN_W  = NOC_LEN_W,
  parameter logic [DEST_W-1:0] MY_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data,
  input  logic              flit_valid,
  input  logic [FLIT_W-1:0] flit,
  output logic              credit_valid,
  output logic [VC_W-1:0]   credit_vc,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [9:0]        pkt_count,
  output logic [15:0]       flit_count
);

  localparam int DST_LSB = dst_lsb(VC_W);

  // Flit field decode.
  logic              flit_head, flit_tail;
  logic [VC_W-1:0]   flit_vc;
  logic [DEST_W-1:0] flit_dst;
  logic              init, accept;

  assign flit_head = flit[HEAD_BIT];
  assign flit_tail = flit[TAIL_BIT];
  assign flit_vc   = flit[VC_LSB +: VC_W];
  assign flit_dst  = flit[DST_LSB +: DEST_W];
  assign init      = (op == OP_INIT);
  // Init takes priority over a coincident flit: the flit is not tracked.
  assign accept    = flit_valid && !init;

  // Payload bits and the low control data bits carry nothing for the sink.
  logic unused_bits;
  assign unused_bits = ^{data[TOTAL_LSB-1:0], flit[FLIT_W-1:DST_LSB+DEST_W]};

  // Per-VC trackers.
  logic [VC_NUM-1:0] pkt_done_v, err_head_v, err_orphan_v, idle_v;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    traffic_sink_vc_tracker #(
      .LEN_W (LEN_W)
    ) u_tracker (
      .clk             (clk),
      .rst             (rst),
      .clr             (init),
      .flit_en         (accept && (flit_vc == VC_W'(g))),
      .head            (flit_head),
      .tail            (flit_tail),
      .pkt_done        (pkt_done_v[g]),
      .err_head_in_pkt (err_head_v[g]),
      .err_orphan      (err_orphan_v[g]),
      .idle            (idle_v[g])
    );
  end

  logic                bad_dest;
  logic                credit_valid_q, credit_valid_d;
  logic [VC_W-1:0]     credit_vc_q, credit_vc_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  err_code_e           err_code_q, err_code_d, err_new;
  logic [9:0]          pkt_count_q, pkt_count_d;
  logic [15:0]         flit_count_q, flit_count_d;
  logic [TOTAL_W-1:0]  expected_q, expected_d;

  assign bad_dest = accept && flit_head && (flit_dst != MY_ADDR);

  // Output and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
      pkt_count_q    <= '0;
      flit_count_q   <= '0;
      expected_q     <= '0;
    end else begin
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      pkt_count_q    <= pkt_count_d;
      flit_count_q   <= flit_count_d;
      expected_q     <= expected_d;
    end
  end

  // Credits, counters, error capture and completion status for next cycle.
  always_comb begin
    // Every consumed flit earns a credit, even one swallowed by Init.
    credit_valid_d = flit_valid;
    credit_vc_d    = flit_valid ? flit_vc : '0;

    // Only one flit per cycle, so at most one error source besides the
    // head/bad-destination pair can fire; priority resolves that pair.
    if (|err_head_v) begin
      err_new = ERR_HEAD_IN_PKT;
    end else if (bad_dest) begin
      err_new = ERR_BAD_DEST;
    end else if (|err_orphan_v) begin
      err_new = ERR_ORPHAN_BODY;
    end else begin
      err_new = ERR_NONE;
    end

    expected_d   = expected_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    pkt_count_d  = pkt_count_q;
    flit_count_d = flit_count_q;

    if (init) begin
      expected_d   = data[TOTAL_LSB +: TOTAL_W];
      error_d      = 1'b0;
      err_code_d   = ERR_NONE;
      pkt_count_d  = '0;
      flit_count_d = '0;
    end else begin
      if (accept) begin
        flit_count_d = flit_count_q + 16'd1;
      end
      if ((|pkt_done_v) && (pkt_count_q != 10'h3FF)) begin
        pkt_count_d = pkt_count_q + 10'd1;
      end
      if (err_new != ERR_NONE) begin
        error_d = 1'b1;
        if (err_code_q == ERR_NONE) begin
          err_code_d = err_new;
        end
      end
    end

    // Completion is evaluated on the values the registers are about to take.
    done_d = (pkt_count_d >= expected_d) && (&idle_v);
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign pkt_count    = pkt_count_q;
  assign flit_count   = flit_count_q;

endmodule
